// File: rtl/mult_seq.sv
// ============================================================================
// mult_seq : iterative WIDTH x WIDTH -> 2*WIDTH multiplier (MULT/MULTU)
// Define MULT_RADIX4_EN for the 2-bits-per-cycle variant.  Rev 1.0
// ============================================================================
`default_nettype none

module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int PW = 2 * WIDTH;
`ifdef MULT_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
  localparam int SH    = 2;
`else
  localparam int STEPS = WIDTH;
  localparam int SH    = 1;
`endif
  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic             neg;
  logic [CW-1:0]    cnt;
`ifdef MULT_RADIX4_EN
  logic [PW-1:0]    mcand3;
`endif

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    addend, acc_next, prod_fix;

  // Operands are reduced to magnitudes; the sign is reapplied to the full product.
  always_comb begin
    neg_a = signed_i & opdata1_i[WIDTH-1];
    neg_b = signed_i & opdata2_i[WIDTH-1];
    abs_a = neg_a ? -opdata1_i : opdata1_i;
    abs_b = neg_b ? -opdata2_i : opdata2_i;
    a_ext = {{WIDTH{1'b0}}, abs_a};
  end

  always_comb begin
    addend = '0;
`ifdef MULT_RADIX4_EN
    case (mplier[1:0])
      2'b01:   addend = mcand;
      2'b10:   addend = {mcand[PW-2:0], 1'b0};
      2'b11:   addend = mcand3;
      default: addend = '0;
    endcase
`else
    if (mplier[0]) addend = mcand;
`endif
    acc_next = acc + addend;
    prod_fix = neg ? -acc_next : acc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
`ifdef MULT_RADIX4_EN
      mcand3   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            state  <= CALC;
            busy_o <= 1'b1;
            mcand  <= a_ext;
            mplier <= abs_b;
            acc    <= '0;
            neg    <= neg_a ^ neg_b;
            cnt    <= '0;
`ifdef MULT_RADIX4_EN
            mcand3 <= a_ext + {a_ext[PW-2:0], 1'b0};
`endif
          end
        end
        CALC: begin
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << SH;
            mplier <= mplier >> SH;
            cnt    <= cnt + CW'(1);
`ifdef MULT_RADIX4_EN
            mcand3 <= mcand3 << 2;
`endif
            if (cnt == CW'(STEPS - 1)) begin
              state    <= DONE;
              busy_o   <= 1'b0;
              ready_o  <= 1'b1;
              result_o <= prod_fix;
            end
          end
        end
        DONE: begin
          // Holding start_i keeps the product visible until the stage consumes it.
          if (annul_i || !start_i) begin
            state    <= IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
